// File: rtl/decode_issue_buf_pkg.sv
// Shared types for the decode-to-execute issue buffer.
// Holds the decoded bundle layout and the default datapath width.
package decode_pkg;

    localparam int XLEN = 64;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] imm;
        logic            with_imm;
    } dec_bundle_t;

endpackage

// File: rtl/decode_issue_buf_if.sv
// Decode-side and execute-side handshake bundle for decode_issue_buf.
// The slave modport is the buffer; the master modport is its environment.
interface decode_issue_buf_if #(
    parameter int XLEN   = 64,
    parameter int CNT_W  = 32,
    parameter int FCNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_data1;
    logic [XLEN-1:0]   in_data2;
    logic [XLEN-1:0]   in_imm;
    logic              in_with_imm;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   data1;
    logic [XLEN-1:0]   data2;
    logic [XLEN-1:0]   imm;
    logic              with_imm;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [FCNT_W-1:0] flush_cnt;

    modport slave (
        input  in_valid, in_pc, in_data1, in_data2, in_imm, in_with_imm,
        input  flush, out_ready,
        output in_ready, out_valid, pc, data1, data2, imm, with_imm,
        output occupancy, stall_cnt, flush_cnt
    );

    modport master (
        output in_valid, in_pc, in_data1, in_data2, in_imm, in_with_imm,
        output flush, out_ready,
        input  in_ready, out_valid, pc, data1, data2, imm, with_imm,
        input  occupancy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/decode_issue_buf_sat_counter.sv
// Event counter that sticks at all-ones; only reset clears it.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);
    logic [W-1:0] r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + W'(1);
        end
    end

    assign value = r_value;
endmodule

// File: rtl/decode_issue_buf.sv
// Two-entry elastic buffer between decode and execute with flush support.
// in_ready is registered so execute back-pressure never reaches decode combinationally.
module decode_issue_buf
    import decode_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int FCNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    decode_issue_buf_if.slave  bus
);
    dec_bundle_t r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        r_in_ready;

    logic        w_out_valid;
    logic        w_enq;
    logic        w_deq;
    logic [1:0]  w_count_next;
    dec_bundle_t w_in;
    dec_bundle_t w_head;

    assign w_in.pc       = bus.in_pc;
    assign w_in.data1    = bus.in_data1;
    assign w_in.data2    = bus.in_data2;
    assign w_in.imm      = bus.in_imm;
    assign w_in.with_imm = bus.in_with_imm;

    assign w_out_valid = (r_count != 2'd0);
    assign w_enq       = bus.in_valid & r_in_ready & ~bus.flush;
    assign w_deq       = w_out_valid & bus.out_ready & ~bus.flush;

    // Flush wins over any same-cycle enqueue or dequeue.
    always_comb begin
        w_count_next = r_count;
        if (bus.flush) begin
            w_count_next = 2'd0;
        end else begin
            w_count_next = r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != 2'd2);
            if (w_enq) begin
                r_mem[r_wr_ptr] <= w_in;
            end
            if (bus.flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_enq) r_wr_ptr <= ~r_wr_ptr;
                if (w_deq) r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // Head fields are never zeroed when empty; they keep showing the slot at rd_ptr.
    assign w_head        = r_mem[r_rd_ptr];
    assign bus.pc        = w_head.pc;
    assign bus.data1     = w_head.data1;
    assign bus.data2     = w_head.data2;
    assign bus.imm       = w_head.imm;
    assign bus.with_imm  = w_head.with_imm;
    assign bus.out_valid = w_out_valid;
    assign bus.in_ready  = r_in_ready;
    assign bus.occupancy = r_count;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_out_valid & ~bus.out_ready & ~bus.flush),
        .value (bus.stall_cnt)
    );

    sat_counter #(.W(FCNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.flush & w_out_valid),
        .value (bus.flush_cnt)
    );
endmodule

// File: tb/tb_decode_issue_buf.sv
// Bench for decode_issue_buf: scenario tasks plus a negedge scoreboard of
// accepted bundles, occupancy, in_ready and both performance counters.
module tb_decode_issue_buf;
    import decode_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_issue_buf_if #(.XLEN(XLEN), .CNT_W(32), .FCNT_W(16)) bus();

    decode_issue_buf #(.CNT_W(32), .FCNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    dec_bundle_t sb_q[$];
    logic        model_ready = 1'b0;
    logic [31:0] model_stall = '0;
    logic [15:0] model_flush = '0;

    function automatic dec_bundle_t mk(input logic [63:0] pc, input logic [63:0] imm, input logic wi);
        dec_bundle_t b;
        b.pc       = pc;
        b.data1    = pc + 64'h11;
        b.data2    = ~pc;
        b.imm      = imm;
        b.with_imm = wi;
        return b;
    endfunction

    task automatic drive(input bit v, input dec_bundle_t b, input bit fl, input bit ordy);
        bus.in_valid    = v;
        bus.in_pc       = b.pc;
        bus.in_data1    = b.data1;
        bus.in_data2    = b.data2;
        bus.in_imm      = b.imm;
        bus.in_with_imm = b.with_imm;
        bus.flush       = fl;
        bus.out_ready   = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: runs every negedge, compares against the model, then advances it.
    task automatic monitor();
        int          sz;
        bit          deq;
        bit          enq;
        dec_bundle_t e;
        if (rst) begin
            sb_q.delete();
            model_ready = 1'b0;
            model_stall = '0;
            model_flush = '0;
            return;
        end
        sz = sb_q.size();
        n_checks++;
        if (bus.in_ready !== model_ready) begin
            n_fail++;
            $display("FAIL in_ready: got %0b expected %0b at %0t", bus.in_ready, model_ready, $time);
        end
        n_checks++;
        if (bus.occupancy !== 2'(sz)) begin
            n_fail++;
            $display("FAIL occupancy: got %0d expected %0d at %0t", bus.occupancy, sz, $time);
        end
        n_checks++;
        if (bus.out_valid !== (sz != 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %0b expected %0b at %0t", bus.out_valid, (sz != 0), $time);
        end
        n_checks++;
        if (bus.stall_cnt !== model_stall) begin
            n_fail++;
            $display("FAIL stall_cnt: got %h expected %h at %0t", bus.stall_cnt, model_stall, $time);
        end
        n_checks++;
        if (bus.flush_cnt !== model_flush) begin
            n_fail++;
            $display("FAIL flush_cnt: got %h expected %h at %0t", bus.flush_cnt, model_flush, $time);
        end
        deq = (sz != 0) && bus.out_ready && !bus.flush;
        enq = bus.in_valid && model_ready && !bus.flush;
        if (deq) begin
            e = sb_q.pop_front();
            n_checks++;
            if ({bus.pc, bus.data1, bus.data2, bus.imm, bus.with_imm} !== e) begin
                n_fail++;
                $display("FAIL head_bundle: got pc=%h imm=%h wi=%0b expected pc=%h imm=%h wi=%0b",
                         bus.pc, bus.imm, bus.with_imm, e.pc, e.imm, e.with_imm);
            end else begin
                $display("deq pc=%h imm=%h wi=%0b", e.pc, e.imm, e.with_imm);
            end
        end
        if (enq) begin
            sb_q.push_back(mk(bus.in_pc, bus.in_imm, bus.in_with_imm));
            sb_q[$].data1 = bus.in_data1;
            sb_q[$].data2 = bus.in_data2;
            $display("enq pc=%h imm=%h wi=%0b", bus.in_pc, bus.in_imm, bus.in_with_imm);
        end
        if ((sz != 0) && !bus.out_ready && !bus.flush && (model_stall != '1)) model_stall++;
        if (bus.flush && (sz != 0) && (model_flush != '1)) model_flush++;
        if (bus.flush) sb_q.delete();
        model_ready = (sb_q.size() != 2);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.occupancy, bus.pc, bus.data1, bus.data2, bus.imm,
                 bus.with_imm, bus.stall_cnt, bus.flush_cnt} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got ov=%0b rdy=%0b occ=%0d pc=%h stall=%h flush=%h expected all zero",
                         bus.out_valid, bus.in_ready, bus.occupancy, bus.pc, bus.stall_cnt, bus.flush_cnt);
            end
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %0b expected 1", bus.in_ready);
        end
        $display("reset done");
    endtask

    task automatic test_streaming();
        logic [63:0] p;
        for (int i = 0; i < 4; i++) begin
            p = 64'h1000 + 64'(4 * i);
            drive(1'b1, mk(p, 64'(i), 1'b0), 1'b0, 1'b1);
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.pc !== p || bus.occupancy > 2'd1) begin
                n_fail++;
                $display("FAIL stream_head: got ov=%0b pc=%h occ=%0d expected ov=1 pc=%h occ<=1",
                         bus.out_valid, bus.pc, bus.occupancy, p);
            end
        end
        drive(1'b0, mk(64'h0, 64'h0, 1'b0), 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL stream_drain: got ov=%0b stall=%h expected ov=0 stall=0", bus.out_valid, bus.stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, mk(64'h2000, 64'h20, 1'b1), 1'b0, 1'b0);
        step();
        n_checks++;
        if (bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first: got occ=%0d rdy=%0b expected occ=1 rdy=1", bus.occupancy, bus.in_ready);
        end
        drive(1'b1, mk(64'h2004, 64'h24, 1'b0), 1'b0, 1'b0);
        step();
        n_checks++;
        if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second: got occ=%0d rdy=%0b expected occ=2 rdy=0", bus.occupancy, bus.in_ready);
        end
        drive(1'b1, mk(64'h2008, 64'h28, 1'b1), 1'b0, 1'b0);
        step();
        step();
        n_checks++;
        if (bus.occupancy !== 2'd2 || bus.pc !== 64'h2000 || bus.stall_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL bp_hold: got occ=%0d pc=%h stall=%0d expected occ=2 pc=2000 stall=3",
                     bus.occupancy, bus.pc, bus.stall_cnt);
        end
        drive(1'b1, mk(64'h2008, 64'h28, 1'b1), 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus.pc !== 64'h2004 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got pc=%h rdy=%0b expected pc=2004 rdy=1", bus.pc, bus.in_ready);
        end
        step();
        drive(1'b0, mk(64'h0, 64'h0, 1'b0), 1'b0, 1'b1);
        step();
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got ov=%0b pending=%0d expected ov=0 pending=0", bus.out_valid, sb_q.size());
        end
    endtask

    task automatic test_flush();
        drive(1'b1, mk(64'h2100, 64'h1, 1'b0), 1'b0, 1'b0);
        step();
        drive(1'b1, mk(64'h2104, 64'h2, 1'b0), 1'b0, 1'b0);
        step();
        drive(1'b1, mk(64'h3000, 64'h3, 1'b0), 1'b1, 1'b1);
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.flush_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL flush_clear: got ov=%0b occ=%0d fcnt=%0d expected ov=0 occ=0 fcnt=1",
                     bus.out_valid, bus.occupancy, bus.flush_cnt);
        end
        drive(1'b0, mk(64'h0, 64'h0, 1'b0), 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got rdy=%0b ov=%0b expected rdy=1 ov=0", bus.in_ready, bus.out_valid);
        end
        drive(1'b0, mk(64'h0, 64'h0, 1'b0), 1'b1, 1'b1);
        step();
        drive(1'b0, mk(64'h0, 64'h0, 1'b0), 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus.flush_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL flush_empty: got fcnt=%0d expected 1", bus.flush_cnt);
        end
    endtask

    task automatic test_simul_enq_deq();
        drive(1'b1, mk(64'h4000, 64'h5, 1'b1), 1'b0, 1'b0);
        step();
        n_checks++;
        if (bus.imm !== 64'h5 || bus.with_imm !== 1'b1 || bus.occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL simul_head: got imm=%h wi=%0b occ=%0d expected imm=5 wi=1 occ=1",
                     bus.imm, bus.with_imm, bus.occupancy);
        end
        drive(1'b1, mk(64'h4004, 64'h7, 1'b0), 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus.imm !== 64'h7 || bus.with_imm !== 1'b0 || bus.occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL simul_next: got imm=%h wi=%0b occ=%0d expected imm=7 wi=0 occ=1",
                     bus.imm, bus.with_imm, bus.occupancy);
        end
        drive(1'b0, mk(64'h0, 64'h0, 1'b0), 1'b0, 1'b1);
        step();
    endtask

    task automatic test_saturation_and_async_reset();
        force dut.u_stall_cnt.r_value = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.r_value;
        model_stall = 32'hFFFF_FFFE;
        drive(1'b1, mk(64'h5000, 64'h9, 1'b1), 1'b0, 1'b0);
        step();
        drive(1'b0, mk(64'h0, 64'h0, 1'b0), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (bus.stall_cnt !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL stall_saturate: got %h expected ffffffff", bus.stall_cnt);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.occupancy, bus.pc, bus.imm, bus.with_imm,
             bus.stall_cnt, bus.flush_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got ov=%0b rdy=%0b occ=%0d pc=%h stall=%h fcnt=%h expected all zero",
                     bus.out_valid, bus.in_ready, bus.occupancy, bus.pc, bus.stall_cnt, bus.flush_cnt);
        end
        step();
        step();
        rst = 1'b0;
        step();
        step();
    endtask

    initial begin
        drive(1'b0, mk(64'h0, 64'h0, 1'b0), 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_simul_enq_deq();
        test_saturation_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_issue_buf.md
# decode_issue_buf

Two-entry elastic buffer between the decode stage and execute. It latches the decoded bundle (pc, data1, data2, imm, with_imm) under a valid/ready handshake and presents it to execute and to the decode debug monitor. It absorbs one cycle of execute back-pressure without a combinational ready path from execute to decode. It supports pipeline flush and keeps saturating stall and flush counters for performance debug.

## Interface
- XLEN, default 64: width of pc/data1/data2/imm.
- CNT_W, default 32: width of the stall counter.
- FCNT_W, default 16: width of the flush counter.

- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents a bundle.
- in_ready  out  1  buffer can accept; registered output.
- in_pc, in_data1, in_data2, in_imm  in  XLEN each  decoded fields.
- in_with_imm  in  1  immediate operand selected.
- flush  in  1  kill all held and incoming bundles this cycle.
- out_valid  out  1  head bundle valid.
- out_ready  in  1  execute consumes the head.
- pc, data1, data2, imm  out  XLEN each  head bundle fields.
- with_imm  out  1  head bundle flag.
- occupancy  out  2  entries held, 0..2.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.
- flush_cnt  out  FCNT_W  flushes that discarded at least one valid entry; saturating.

## Operation
- Storage: 2-entry ring. State is 1-bit wr_ptr, 1-bit rd_ptr and 2-bit count.
- Enqueue (enq) when in_valid & in_ready & ~flush. Write the slot at wr_ptr, then toggle wr_ptr.
- Dequeue (deq) when out_valid & out_ready & ~flush. Toggle rd_ptr.
- Count update: count_next = count + enq − deq.
- Counter saturation: in_ready is 0 at count 2, so enq cannot occur at count 2 and count never exceeds 2. Count 0 implies out_valid=0, so deq cannot occur at count 0.
- Same-cycle enq and deq at count 1: count stays 1. The new bundle becomes head the next cycle.
- Output fields are driven from the slot at rd_ptr.
  - out_valid = (count != 0).
  - When out_valid=0, outputs hold the last head contents; they are not zeroed.
- in_ready is registered: in_ready_q <= (count_next != 2). in_ready does not depend combinationally on out_ready.
- Flush has priority over enq and deq:
  - count, wr_ptr and rd_ptr go to 0.
  - Any same-cycle input bundle is dropped and any same-cycle output bundle is not counted as consumed.
  - in_ready goes to 1 the next cycle.
- flush_cnt increments when flush=1 and count != 0.
- stall_cnt increments when out_valid=1, out_ready=0 and flush=0.
- Both counters stick at all-ones. Only rst clears them.

## Timing
- Reset values while rst=1:
  - out_valid=0, in_ready=0, occupancy=0.
  - pc/data1/data2/imm=0, with_imm=0.
  - stall_cnt=0, flush_cnt=0, pointers=0.
- in_ready is 1 on the first clock edge after rst deasserts.
- Latency: a bundle accepted at edge N is visible on the outputs with out_valid=1 after edge N (one cycle) when the buffer was empty.
- Throughput: one bundle per cycle while out_ready=1 continuously.
- Back-pressure, starting from empty with out_ready=0:
  - The first bundle is accepted and count becomes 1; in_ready stays 1.
  - The second bundle is accepted and count becomes 2; in_ready drops to 0 one cycle after that.
  - in_ready returns to 1 the cycle after the first deq.
- Reset asserted mid-operation: all held entries are lost immediately (asynchronous clear) with no partial output.
- Counter updates take effect on the same edge as the qualifying cycle.

## Structure
- Package decode_pkg:
  - typedef dec_bundle_t = struct {pc, data1, data2, imm, with_imm}, 4×XLEN+1 bits.
  - XLEN constant.
- Storage is an array of two dec_bundle_t.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, value), instantiated twice: once for stall_cnt, once for flush_cnt.

## Test plan
- Reset check: hold rst for 3 cycles, then release. Required: all outputs 0 during reset; in_ready=1 one edge after release.
- Streaming: out_ready=1; 4 bundles with pc=0x1000, 0x1004, 0x1008, 0x100c on consecutive cycles. Required: the same pcs appear in order, one cycle later each; stall_cnt=0; occupancy never exceeds 1.
- Back-pressure: out_ready=0; offer pc=0x2000, 0x2004, 0x2008. Required: first two accepted; in_ready=0 from the cycle after the second accept; 0x2008 held off; stall_cnt increments each stalled cycle. Then out_ready=1: outputs 0x2000, 0x2004, 0x2008 in order.
- Flush: with 2 entries held and in_valid=1 (pc=0x3000), assert flush for 1 cycle. Required:
  - out_valid=0 and occupancy=0 next cycle, and 0x3000 is never output.
  - flush_cnt increments by 1.
  - A second flush while empty leaves flush_cnt unchanged.
- Simultaneous enq/deq: at count 1 (head imm=0x5, with_imm=1), enq imm=0x7 with out_ready=1. Required: occupancy stays 1; next head imm=0x7, with_imm as driven.
- Saturation and async reset: preload stall_cnt to 0xFFFFFFFE (force), then stall 3 cycles. Required: counter holds 0xFFFFFFFF. Then assert rst between edges. Required: all outputs clear immediately, without waiting for a clock edge.
